// File: rtl/drops_engine_if.sv
// Signal bundle between the drops game engine and its surroundings.
// The engine takes the slave side, and whatever drives the buttons takes the master side.
interface drops_engine_if #(
    parameter int GS      = 8,
    parameter int SCORE_W = 8
);
    // No valid/ready pairs. ena and the button/pause levels are sampled on
    // every rising edge. hit_o and miss_o are single-cycle strobes with no
    // backpressure. The other outputs are registered levels.
    logic               ena;
    logic               left_i;
    logic               right_i;
    logic               pause_i;
    logic [GS-1:0]      row_o;
    logic [GS-1:0]      col_o;
    logic [SCORE_W-1:0] score_o;
    logic [3:0]         lives_o;
    logic [1:0]         state_o;
    logic               hit_o;
    logic               miss_o;

    modport master (
        output ena, left_i, right_i, pause_i,
        input  row_o, col_o, score_o, lives_o, state_o, hit_o, miss_o
    );

    modport slave (
        input  ena, left_i, right_i, pause_i,
        output row_o, col_o, score_o, lives_o, state_o, hit_o, miss_o
    );
endinterface

// File: rtl/drops_engine.sv
// Falling-drops catch game: a debounced left/right player on the bottom row of a GSxGS grid,
// LFSR-spawned drops, score/lives bookkeeping and a row-scanned matrix display.
module drops_engine #(
    parameter int          GS          = 8,
    parameter int          FALL_PERIOD = 1000,
    parameter int          DEB_CYC     = 4,
    parameter int          LIVES       = 3,
    parameter int          SCORE_W     = 8,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input logic           clk,
    input logic           rst_n,
    drops_engine_if.slave bus
);
    localparam int LG = $clog2(GS);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int TW = $clog2(FALL_PERIOD);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYC);
    localparam logic [TW-1:0] TICK_LAST = TW'(FALL_PERIOD - 1);
    localparam logic [LG-1:0] POS_HOME  = LG'(GS / 2);
    localparam logic [LG-1:0] POS_MAX   = LG'(GS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [GS-2:0][GS-1:0]   field_q, field_d;
    logic [LG-1:0]           pos_q, pos_d;
    logic [SCORE_W-1:0]      score_q, score_d;
    logic [3:0]              lives_q, lives_d;
    logic [TW-1:0]           tick_q, tick_d;
    logic [DW-1:0]           deb_l_q, deb_l_d;
    logic [DW-1:0]           deb_r_q, deb_r_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [LG-1:0]           scan_q, scan_d;
    logic [GS-1:0]           row_q, row_d;
    logic [GS-1:0]           col_q, col_d;
    logic                    hit_q, hit_d;
    logic                    miss_q, miss_d;

    logic                    ev_l, ev_r, ev_any;
    logic                    step_hit, step_miss;
    logic [GS-1:0]           spawn_row;

    always_comb begin
        state_d   = state_q;
        field_d   = field_q;
        pos_d     = pos_q;
        score_d   = score_q;
        lives_d   = lives_q;
        tick_d    = tick_q;
        deb_l_d   = deb_l_q;
        deb_r_d   = deb_r_q;
        lfsr_d    = lfsr_q;
        scan_d    = scan_q;
        row_d     = row_q;
        col_d     = col_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        ev_l      = 1'b0;
        ev_r      = 1'b0;
        ev_any    = 1'b0;
        step_hit  = 1'b0;
        step_miss = 1'b0;
        spawn_row = '0;

        if (bus.ena) begin
            // The event fires on the sample that completes the stable run, so holding a button cannot repeat it.
            ev_l    = bus.left_i  && (deb_l_q == DEB_MAX - 1'b1);
            ev_r    = bus.right_i && (deb_r_q == DEB_MAX - 1'b1);
            ev_any  = ev_l || ev_r;
            deb_l_d = !bus.left_i  ? '0 : (deb_l_q == DEB_MAX ? deb_l_q : deb_l_q + 1'b1);
            deb_r_d = !bus.right_i ? '0 : (deb_r_q == DEB_MAX ? deb_r_q : deb_r_q + 1'b1);

            scan_d = scan_q + 1'b1;
            row_d  = '0;
            row_d[scan_q] = 1'b1;
            if (scan_q == POS_MAX) begin
                col_d = '0;
                if (state_q == ST_OVER) col_d = '1;
                else                    col_d[pos_q] = 1'b1;
            end else begin
                col_d = field_q[scan_q];
            end

            if (lfsr_q[0]) spawn_row[lfsr_q[LG:1]] = 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (ev_any) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (ev_l && !ev_r && pos_q != '0)         pos_d = pos_q - 1'b1;
                    else if (ev_r && !ev_l && pos_q != POS_MAX) pos_d = pos_q + 1'b1;

                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        // Judged against pos_q, so a move landing on the step cycle is too late to catch.
                        step_hit  = field_q[GS-2][pos_q];
                        step_miss = (|field_q[GS-2]) && !step_hit;
                        if (step_hit) begin
                            hit_d = 1'b1;
                            if (score_q != '1) score_d = score_q + 1'b1;
                        end
                        if (step_miss) begin
                            miss_d  = 1'b1;
                            lives_d = lives_q - 4'd1;
                        end
                        for (int i = 1; i < GS - 1; i++) field_d[i] = field_q[i-1];
                        field_d[0] = spawn_row;
                        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end

                    if (step_miss && lives_q == 4'd1) state_d = ST_OVER;
                    else if (bus.pause_i)             state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (!bus.pause_i) state_d = ST_RUN;
                end
                ST_OVER: begin
                    if (ev_any) begin
                        state_d = ST_IDLE;
                        field_d = '0;
                        score_d = '0;
                        lives_d = 4'(LIVES);
                        pos_d   = POS_HOME;
                        tick_d  = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            field_q <= '0;
            pos_q   <= POS_HOME;
            score_q <= '0;
            lives_q <= 4'(LIVES);
            tick_q  <= '0;
            deb_l_q <= '0;
            deb_r_q <= '0;
            lfsr_q  <= SEED;
            scan_q  <= '0;
            row_q   <= GS'(1);
            col_q   <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            pos_q   <= pos_d;
            score_q <= score_d;
            lives_q <= lives_d;
            tick_q  <= tick_d;
            deb_l_q <= deb_l_d;
            deb_r_q <= deb_r_d;
            lfsr_q  <= lfsr_d;
            scan_q  <= scan_d;
            row_q   <= row_d;
            col_q   <= col_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    assign bus.row_o   = row_q;
    assign bus.col_o   = col_q;
    assign bus.score_o = score_q;
    assign bus.lives_o = lives_q;
    assign bus.state_o = state_q;
    assign bus.hit_o   = hit_q;
    assign bus.miss_o  = miss_q;
endmodule
